// File: rtl/axis_pkt_store_fwd_pkg.sv
// Shared types for the store-and-forward AXIS packet FIFO.
package axis_pkt_store_fwd_pkg;

  typedef enum logic [0:0] {
    WR   = 1'b0,
    DROP = 1'b1
  } wr_state_e;

  // One extra pointer bit tells full apart from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/axis_pkt_store_fwd_ram.sv
// Beat storage: simple dual-port array, synchronous write, asynchronous read.
module pkt_store_ram
  import axis_pkt_store_fwd_pkg::*;
#(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents need no reset, only the slots between pointers matter
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axis_pkt_store_fwd.sv
// Store-and-forward AXIS FIFO: a packet becomes visible only once its tlast is stored.
// Optional drop statistics are built when AXIS_PKT_STORE_FWD_STATS_EN is defined.
module axis_pkt_store_fwd
  import axis_pkt_store_fwd_pkg::*;
#(
  parameter int TDATA_WIDTH    = 64,
  parameter int TID_WIDTH      = 2,
  parameter int TDEST_WIDTH    = 2,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                         clk_usr,
  input  logic                         rst_usr_sync,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic [TID_WIDTH-1:0]         s_axis_tid,
  input  logic [TDEST_WIDTH-1:0]       s_axis_tdest,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [TID_WIDTH-1:0]         m_axis_tid,
  output logic [TDEST_WIDTH-1:0]       m_axis_tdest,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
  output logic                         drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_r, rd_ptr_r, commit_ptr_r;
  logic [PW-1:0] used_s, partial_s;
  wr_state_e     state_r;
  logic [CW-1:0] pkt_count_r;
  logic          full_s, oversize_s, s_ready_s, wr_hs_s, wr_en_s, commit_s;
  logic          m_valid_s, rd_hs_s, rd_last_s;
  logic [DW-1:0] wr_data_s, rd_data_s;

  // Occupancy, handshakes and the oversize condition
  always_comb begin
    used_s     = wr_ptr_r - rd_ptr_r;
    partial_s  = wr_ptr_r - commit_ptr_r;
    full_s     = (used_s == DEPTH_P);
    oversize_s = (state_r == WR) && (partial_s == DEPTH_P);
    case (state_r)
      WR:      s_ready_s = !full_s && !oversize_s;
      DROP:    s_ready_s = 1'b1;
      default: s_ready_s = 1'b0;
    endcase
    wr_hs_s   = s_axis_tvalid && s_ready_s;
    wr_en_s   = wr_hs_s && (state_r == WR);
    commit_s  = wr_en_s && s_axis_tlast;
    m_valid_s = (rd_ptr_r != commit_ptr_r);
    rd_hs_s   = m_valid_s && m_axis_tready;
    rd_last_s = rd_hs_s && rd_data_s[TID_WIDTH+TDEST_WIDTH];
  end

  assign wr_data_s = {s_axis_tdata, s_axis_tlast, s_axis_tid, s_axis_tdest};
  assign {m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest} = rd_data_s;
  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = m_valid_s;
  assign pkt_count     = pkt_count_r;

  // Write FSM: an oversize packet rewinds to the last commit point and is skipped to its tlast
  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      wr_ptr_r     <= '0;
      commit_ptr_r <= '0;
      state_r      <= WR;
    end else begin
      case (state_r)
        WR: begin
          if (oversize_s) begin
            wr_ptr_r <= commit_ptr_r;
            state_r  <= DROP;
          end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (s_axis_tlast) begin
              commit_ptr_r <= wr_ptr_r + PTR_ONE;
            end
          end
        end
        DROP: begin
          if (wr_hs_s && s_axis_tlast) begin
            state_r <= WR;
          end
        end
        default: state_r <= WR;
      endcase
    end
  end

  // Read pointer and complete-packet count; a commit and a tlast read on one edge cancel
  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      rd_ptr_r    <= '0;
      pkt_count_r <= '0;
    end else begin
      if (rd_hs_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({commit_s, rd_last_s})
        2'b10:   pkt_count_r <= pkt_count_r + CNT_ONE;
        2'b01:   pkt_count_r <= pkt_count_r - CNT_ONE;
        default: pkt_count_r <= pkt_count_r;
      endcase
    end
  end

`ifdef AXIS_PKT_STORE_FWD_STATS_EN
  logic                      drop_pulse_r;
  logic [DROP_CNT_WIDTH-1:0] drop_count_r;

  // Drop statistics, counter saturates at all-ones
  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      drop_pulse_r <= 1'b0;
      drop_count_r <= '0;
    end else begin
      drop_pulse_r <= oversize_s;
      if (oversize_s && (drop_count_r != {DROP_CNT_WIDTH{1'b1}})) begin
        drop_count_r <= drop_count_r + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign drop_pulse = drop_pulse_r;
  assign drop_count = drop_count_r;
`else
  assign drop_pulse = 1'b0;
  assign drop_count = '0;
`endif

  pkt_store_ram #(
    .WIDTH (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk_usr),
    .we    (wr_en_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wr_data_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rd_data_s)
  );

endmodule

// File: tb/tb_axis_pkt_store_fwd.sv
// Directed and randomized bench for axis_pkt_store_fwd with an order-preserving scoreboard.
module tb_axis_pkt_store_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [1:0]  s_tid, s_tdest;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [1:0]  m_tid, m_tdest;
  logic [4:0]  pkt_count;
  logic        drop_pulse;
  logic [15:0] drop_count;

`ifdef AXIS_PKT_STORE_FWD_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif

  int          total = 0, passed = 0, drop_seen = 0, stalls = 0;
  logic [68:0] q[$];
  logic        push_en = 1'b1, last_s_hs = 1'b0, prev_stall = 1'b0;
  logic [68:0] prev_pl = '0;

  always #5 clk = ~clk;

  axis_pkt_store_fwd dut (
    .clk_usr(clk), .rst_usr_sync(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .pkt_count(pkt_count), .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called mid-low-phase: inputs are stable, so these are the handshakes of the coming edge.
  task automatic sample();
    logic [68:0] pl, ex;
    pl = {m_tdata, m_tlast, m_tid, m_tdest};
    last_s_hs = s_tvalid && s_tready && !rst;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (drop_pulse) drop_seen++;
      if (prev_stall) begin
        check("hold_valid", 128'(m_tvalid), 128'(1'b1));
        check("hold_payload", 128'(pl), 128'(prev_pl));
      end
      if (m_tvalid && m_tready) begin
        total++;
        assert (q.size() > 0) passed++;
        else $error("FAIL unexpected_beat: observed beat %0h expected no beat", pl);
        if (q.size() > 0) begin
          ex = q.pop_front();
          check("beat_payload", 128'(pl), 128'(ex));
        end
      end
      if (last_s_hs && push_en) q.push_back({s_tdata, s_tlast, s_tid, s_tdest});
      prev_stall = m_tvalid && !m_tready;
      prev_pl    = pl;
    end
  endtask

  task automatic cyc();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l,
                       input logic [1:0] id, input logic [1:0] de);
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tid = id; s_tdest = de;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send_pkt(input int len, input logic [1:0] id, input logic [1:0] de,
                          input logic [63:0] base, output int st);
    int n;
    st = 0;
    for (int i = 0; i < len; i++) begin
      drive(1'b1, base + 64'(i), (i == len - 1), id, de);
      n = 0;
      cyc();
      while (!last_s_hs && n < 64) begin
        st++; n++;
        cyc();
      end
      if (!last_s_hs) check("s_accept_timeout", 128'(last_s_hs), 128'(1'b1));
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          pk, bi, len, cycles;
    logic [1:0]  rid, rde;
    rst = 1'b1; m_tready = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
    @(negedge clk);
    cyc(); cyc();
    // reset state
    #1;
    check("rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    check("rst_pkt_count", 128'(pkt_count), 128'(5'd0));
    check("rst_drop_pulse", 128'(drop_pulse), 128'(1'b0));
    check("rst_drop_count", 128'(drop_count), 128'(16'd0));
    rst = 1'b0;
    cyc();
    check("rst_s_tready", 128'(s_tready), 128'(1'b1));

    // 1: 3-beat packet, tvalid only after tlast stored
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hA000_0000_0000_0000 + 64'(i), (i == 2), 2'd1, 2'd2);
      #1;
      check("t1_no_valid_before_tlast", 128'(m_tvalid), 128'(1'b0));
      check("t1_s_tready", 128'(s_tready), 128'(1'b1));
      cyc();
    end
    s_tvalid = 1'b0;
    #1;
    check("t1_valid_after_tlast", 128'(m_tvalid), 128'(1'b1));
    check("t1_pkt_count_1", 128'(pkt_count), 128'(5'd1));
    check("t1_first_data", 128'(m_tdata), 128'(64'hA000_0000_0000_0000));
    check("t1_tid", 128'(m_tid), 128'(2'd1));
    check("t1_tdest", 128'(m_tdest), 128'(2'd2));
    cyc(); cyc(); cyc();
    #1;
    check("t1_pkt_count_0", 128'(pkt_count), 128'(5'd0));
    check("t1_drained", 128'(m_tvalid), 128'(1'b0));
    cyc();

    // 2: fill with two 8-beat packets under backpressure
    m_tready = 1'b0;
    send_pkt(8, 2'd0, 2'd1, 64'hB100, stalls);
    send_pkt(8, 2'd3, 2'd0, 64'hB200, stalls);
    #1;
    check("t2_full_s_tready", 128'(s_tready), 128'(1'b0));
    check("t2_pkt_count_2", 128'(pkt_count), 128'(5'd2));
    cyc();
    m_tready = 1'b1;
    repeat (8) cyc();
    m_tready = 1'b0;
    #1;
    check("t2_s_tready_back", 128'(s_tready), 128'(1'b1));
    check("t2_pkt_count_1", 128'(pkt_count), 128'(5'd1));
    cyc();
    m_tready = 1'b1;
    idle(10);
    check("t2_pkt_count_0", 128'(pkt_count), 128'(5'd0));

    // 3: 20-beat packet is dropped whole, next packet passes
    push_en = 1'b0; drop_seen = 0;
    send_pkt(20, 2'd2, 2'd3, 64'hC000, stalls);
    push_en = 1'b1;
    check("t3_stall_cycles", 128'(stalls), 128'(1));
    idle(3);
    check("t3_drop_pulses", 128'(drop_seen), 128'(STATS ? 1 : 0));
    check("t3_drop_count", 128'(drop_count), 128'({15'd0, STATS}));
    check("t3_pkt_count", 128'(pkt_count), 128'(5'd0));
    send_pkt(2, 2'd1, 2'd1, 64'hC100, stalls);
    check("t3_small_stalls", 128'(stalls), 128'(0));
    idle(5);
    check("t3_small_delivered", 128'(q.size()), 128'(0));

    // 4: commit of A and tlast read of B on the same edge
    m_tready = 1'b0;
    send_pkt(2, 2'd2, 2'd2, 64'hD0B0, stalls);
    drive(1'b1, 64'hD0A0, 1'b0, 2'd3, 2'd1);
    cyc();
    drive(1'b1, 64'hD0A1, 1'b0, 2'd3, 2'd1);
    m_tready = 1'b1;
    cyc();
    drive(1'b1, 64'hD0A2, 1'b1, 2'd3, 2'd1);
    #1;
    check("t4_b_tlast_at_head", 128'(m_tlast), 128'(1'b1));
    check("t4_pkt_count_before", 128'(pkt_count), 128'(5'd1));
    cyc();
    s_tvalid = 1'b0;
    #1;
    check("t4_pkt_count_after", 128'(pkt_count), 128'(5'd1));
    check("t4_a_head_data", 128'(m_tdata), 128'(64'hD0A0));
    idle(5);
    check("t4_pkt_count_0", 128'(pkt_count), 128'(5'd0));

    // 5: reset with a partial packet stored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'hE000 + 64'(i), 1'b0, 2'd0, 2'd0);
      cyc();
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    cyc();
    q.delete();
    rst = 1'b0;
    #1;
    check("t5_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    check("t5_pkt_count", 128'(pkt_count), 128'(5'd0));
    check("t5_s_tready", 128'(s_tready), 128'(1'b1));
    check("t5_drop_count", 128'(drop_count), 128'(16'd0));
    cyc();
    idle(6);
    send_pkt(1, 2'd1, 2'd3, 64'hE100, stalls);
    idle(4);
    check("t5_after_reset_delivered", 128'(q.size()), 128'(0));

    // 6: random traffic
    pk = 0; bi = 0; len = 1; cycles = 0; rid = 2'd0; rde = 2'd0;
    while (pk < 200 && cycles < 20000) begin
      m_tready = ($urandom_range(3, 0) != 0);
      if (!s_tvalid && $urandom_range(3, 0) != 0) begin
        if (bi == 0) begin
          len = int'($urandom_range(16, 1));
          rid = 2'($urandom_range(3, 0));
          rde = 2'($urandom_range(3, 0));
        end
        drive(1'b1, {$urandom, $urandom}, (bi == len - 1), rid, rde);
      end
      cyc();
      cycles++;
      if (last_s_hs) begin
        s_tvalid = 1'b0;
        if (bi == len - 1) begin bi = 0; pk++; end
        else bi++;
      end
    end
    check("t6_all_sent", 128'(pk), 128'(200));
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    cycles = 0;
    while (q.size() != 0 && cycles < 400) begin cyc(); cycles++; end
    cyc();
    check("t6_drained", 128'(q.size()), 128'(0));
    check("t6_pkt_count_0", 128'(pkt_count), 128'(5'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_pkt_store_fwd.md
Name: axis_pkt_store_fwd

Overview:
Store-and-forward packet FIFO on the user-clock side, directly upstream of the router wrapper's AXIS injection port (axis_in_*).
- Accepts AXIS beats from the user and buffers them.
- Presents a packet downstream only after its tlast beat is stored, so the injection shim never stalls mid-packet on a slow producer.
- Packets longer than the buffer are dropped whole.

Parameters:
TDATA_WIDTH, 64, data beat width
TID_WIDTH, 2, tid width
TDEST_WIDTH, 2, tdest width
DEPTH, 16, beat capacity; power of two, >=4
DROP_CNT_WIDTH, 16, width of drop counter

Ports:
clk_usr  in  1  user clock
rst_usr_sync  in  1  reset
s_axis_tvalid  in  1  upstream beat valid
s_axis_tready  out  1  upstream ready
s_axis_tdata  in  TDATA_WIDTH  beat data
s_axis_tlast  in  1  end of packet
s_axis_tid  in  TID_WIDTH  id
s_axis_tdest  in  TDEST_WIDTH  destination
m_axis_tvalid  out  1  to router_wrap axis_in_tvalid
m_axis_tready  in  1  from axis_in_tready
m_axis_tdata  out  TDATA_WIDTH  beat data
m_axis_tlast  out  1  end of packet
m_axis_tid  out  TID_WIDTH  id
m_axis_tdest  out  TDEST_WIDTH  destination
pkt_count  out  $clog2(DEPTH+1)  complete packets stored
drop_pulse  out  1  one-cycle pulse per dropped packet
drop_count  out  DROP_CNT_WIDTH  saturating dropped-packet count

Behaviour:
Clocking and reset
- Single clock clk_usr. Reset rst_usr_sync is synchronous, active-high.
- Reset values: rd_ptr=wr_ptr=commit_ptr=0, state=WR, pkt_count=0, drop_pulse=0, drop_count=0, m_axis_tvalid=0. s_axis_tready=1 in the first cycle after reset.
- Reset mid-packet discards all stored and partial data; no beat emitted.

Storage
- DEPTH entries of {tdata,tlast,tid,tdest}.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- used = wr_ptr-rd_ptr; full = (used==DEPTH); partial = wr_ptr-commit_ptr.

Write FSM states: WR, DROP.
- WR:
  - s_axis_tready = !full && (partial!=DEPTH).
  - On handshake: write beat at wr_ptr, wr_ptr++.
  - If tlast: commit_ptr <= wr_ptr+1 and pkt_count++.
  - Oversize: if partial==DEPTH (registered), then next edge wr_ptr <= commit_ptr, state <= DROP, drop_pulse=1 for one cycle, drop_count++ (saturates at all-ones). tready=0 in that cycle.
  - A packet of exactly DEPTH beats commits normally.
- DROP:
  - s_axis_tready=1; beats discarded.
  - A handshake with tlast returns to WR.
  - Storage is untouched.

Read side
- m_axis_tvalid = (rd_ptr != commit_ptr). Payload is a combinational read at rd_ptr.
- On handshake rd_ptr++. If the beat's tlast: pkt_count--.
- Commit and tlast-read on the same edge: pkt_count unchanged.
- Latency: tvalid rises in the cycle after the edge that accepted tlast (empty FIFO).
- Payload is held stable while tvalid && !tready (AXIS rule).
- Beats leave in arrival order; packets are never interleaved.

Optional Feature:
AXIS_PKT_STORE_FWD_STATS_EN
- Defined: drop_count and drop_pulse behave as above.
- Undefined: both are tied 0 and the counter logic is removed; the drop mechanism itself still operates.

Decomposition:
- Package axis_pkt_store_fwd_pkg: write-state enum (WR, DROP) and the pointer-width function clog2 plus 1.
- One sub-module, pkt_store_ram: simple dual-port array, synchronous write, asynchronous read, DEPTH x (TDATA_WIDTH+1+TID_WIDTH+TDEST_WIDTH).

Test Plan:
1. Empty FIFO, 3-beat packet tid=1, tdest=2, m_tready=1 -> m_tvalid stays 0 until tlast is accepted; high the next cycle; 3 beats out with tlast on the 3rd; tid/tdest preserved; pkt_count 1->0.
2. Two 8-beat packets, m_tready=0 -> full, s_tready=0, pkt_count=2. Raise m_tready for 8 beats -> s_tready returns to 1.
3. 20-beat packet, DEPTH=16 -> 16 beats accepted, tready low one cycle, drop_pulse=1, drop_count=1. Remaining 4 beats accepted and discarded; no output. A following 2-beat packet passes intact.
4. Packet A's tlast accepted on the same edge packet B's tlast is read -> pkt_count unchanged; data correct.
5. Reset asserted with 5 beats of an incomplete packet stored -> m_tvalid=0, pkt_count=0, s_tready=1 next cycle; the partial packet never appears.
6. 200 random-length packets (1-16 beats), random s_tvalid/m_tready -> scoreboard shows exact order and data; no tvalid-drop or payload change under backpressure.
